// File: rtl/ddr_rst_pkg.sv
// Shared state encoding and counter widths for the DDR reset sequencer.
package ddr_rst_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOSS_W  = 8;
  localparam int unsigned MS_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_INIT = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLDOFF   = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  // Saturating increment for the loss counter.
  function automatic logic [LOSS_W-1:0] loss_sat_inc(input logic [LOSS_W-1:0] v);
    return (v == '1) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/ddr_rst_seq_ctrl_ms_prescaler.sv
// Millisecond prescaler: registered tick on the last count of each TICK_DIV window.
module ms_prescaler #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned      CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // tick_q tracks (cnt_q == CNT_LAST) without a combinational decode on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ddr_rst_seq_ctrl.sv
// DDR controller reset sequencer: reset pulse, init-done wait with timeout/retry,
// run-time loss detection and re-sequencing.
module ddr_rst_seq_ctrl
  import ddr_rst_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 50000,
  parameter int unsigned RST_PULSE_CYC = 200,
  parameter int unsigned TIMEOUT_MS    = 1000,
  parameter int unsigned HOLDOFF_MS    = 15,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned DROP_CYC      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               local_init_done,
  output logic               ddr_rst_out,
  output logic               init_ok,
  output logic               init_fail,
  output logic [STATE_W-1:0] state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt,
  output logic               ms_tick
);

  localparam int unsigned PULSE_W = $clog2(RST_PULSE_CYC + 1);
  localparam int unsigned DROP_W  = $clog2(DROP_CYC + 1);

  localparam logic [PULSE_W-1:0] PULSE_LAST  = PULSE_W'(RST_PULSE_CYC - 1);
  localparam logic [DROP_W-1:0]  DROP_LAST   = DROP_W'(DROP_CYC - 1);
  localparam logic [DROP_W-1:0]  DROP_MAX    = DROP_W'(DROP_CYC);
  localparam logic [MS_W-1:0]    TIMEOUT_TGT = MS_W'(TIMEOUT_MS);
  localparam logic [MS_W-1:0]    HOLDOFF_TGT = MS_W'(HOLDOFF_MS);
  localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic               sync1_q, init_s_q;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [MS_W-1:0]    ms_q, ms_d, ms_tgt_c;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               ddr_rst_q, init_ok_q, init_fail_q;
  logic               state_chg_c, expire_c, tick_w;

  ms_prescaler #(.TICK_DIV(TICK_DIV)) u_ms_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_chg_c),
    .tick (tick_w)
  );

  // Expiry fires on the tick that would bring the ms counter to its target.
  assign ms_tgt_c    = (state_q == ST_WAIT_INIT) ? TIMEOUT_TGT : HOLDOFF_TGT;
  assign expire_c    = tick_w && (ms_q == (ms_tgt_c - MS_W'(1)));
  assign state_chg_c = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (pulse_q == PULSE_LAST) state_d = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: begin
        if (init_s_q) begin
          state_d = ST_RUN;
          retry_d = '0;
        end else if (expire_c) begin
          if (retry_q >= RETRY_LIM) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_HOLDOFF;
            retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (!init_s_q && (drop_q == DROP_LAST)) begin
          state_d = ST_HOLDOFF;
          loss_d  = loss_sat_inc(loss_q);
        end
      end
      ST_HOLDOFF: begin
        if (expire_c) state_d = ST_RESET;
      end
      ST_FAIL: begin
        if (clear) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disable overrides everything except a latched failure.
    if (!enable && (state_q != ST_FAIL)) begin
      state_d = ST_IDLE;
      retry_d = '0;
      loss_d  = loss_q;
    end
  end

  always_comb begin
    pulse_d = '0;
    drop_d  = '0;
    ms_d    = '0;
    if (!state_chg_c) begin
      if ((state_q == ST_RESET) && (pulse_q != PULSE_LAST)) pulse_d = pulse_q + PULSE_W'(1);
      if ((state_q == ST_RUN) && !init_s_q) begin
        drop_d = (drop_q == DROP_MAX) ? drop_q : drop_q + DROP_W'(1);
      end
      ms_d = (tick_w && (ms_q != ms_tgt_c)) ? ms_q + MS_W'(1) : ms_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      init_s_q    <= 1'b0;
      pulse_q     <= '0;
      drop_q      <= '0;
      ms_q        <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      ddr_rst_q   <= 1'b0;
      init_ok_q   <= 1'b0;
      init_fail_q <= 1'b0;
    end else begin
      sync1_q     <= local_init_done;
      init_s_q    <= sync1_q;
      pulse_q     <= pulse_d;
      drop_q      <= drop_d;
      ms_q        <= ms_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      ddr_rst_q   <= (state_d == ST_RESET);
      init_ok_q   <= (state_d == ST_RUN);
      init_fail_q <= (state_d == ST_FAIL);
    end
  end

  assign ddr_rst_out = ddr_rst_q;
  assign init_ok     = init_ok_q;
  assign init_fail   = init_fail_q;
  assign state       = state_q;
  assign retry_cnt   = retry_q;
  assign loss_cnt    = loss_q;
  assign ms_tick     = tick_w;

endmodule

// File: tb/tb_ddr_rst_seq_ctrl.sv
// Directed bench for ddr_rst_seq_ctrl with small timing parameters.
module tb_ddr_rst_seq_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_RESET = 3'd1, S_WAIT = 3'd2,
                         S_RUN = 3'd3, S_HOLD = 3'd4, S_FAIL = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n, enable, clear, local_init_done;
  logic       ddr_rst_out, init_ok, init_fail, ms_tick;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ddr_rst_seq_ctrl #(
    .TICK_DIV(10), .RST_PULSE_CYC(5), .TIMEOUT_MS(4),
    .HOLDOFF_MS(2), .MAX_RETRY(2), .DROP_CYC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .local_init_done(local_init_done), .ddr_rst_out(ddr_rst_out),
    .init_ok(init_ok), .init_fail(init_fail), .state(state),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .ms_tick(ms_tick)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for a state; an expired bound is a miscompare.
  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (state !== st && n < budget) begin
      step();
      n++;
    end
    vectors++;
    if (state !== st) begin
      miscompares++;
      $display("FAIL %s: wait expired, state=%0d required=%0d", tag, state, st);
    end
  endtask

  task automatic count_state(input logic [2:0] st, output int n);
    n = 0;
    while (state === st && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; local_init_done = 1'b0;
    step(3);
    vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want 0", state); end
    vectors++; if (ddr_rst_out !== 1'b0) begin miscompares++; $display("FAIL rst_ddr: got %0b want 0", ddr_rst_out); end
    vectors++; if (init_ok !== 1'b0 || init_fail !== 1'b0) begin miscompares++; $display("FAIL rst_flags: got ok=%0b fail=%0b want 0/0", init_ok, init_fail); end
    vectors++; if (retry_cnt !== 4'd0 || loss_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_cnts: got retry=%0d loss=%0d want 0/0", retry_cnt, loss_cnt); end
    vectors++; if (ms_tick !== 1'b0) begin miscompares++; $display("FAIL rst_tick: got %0b want 0", ms_tick); end
    rst_n = 1'b1;
    step();
    vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL idle_hold: got %0d want 0", state); end
  endtask

  task automatic test_happy();
    int n;
    enable = 1'b1;
    step();
    n = 0;
    while (ddr_rst_out === 1'b1 && n < 50) begin n++; step(); end
    vectors++; if (n !== 5) begin miscompares++; $display("FAIL pulse_len: got %0d want 5", n); end
    vectors++; if (state !== S_WAIT) begin miscompares++; $display("FAIL wait_entry: got %0d want 2", state); end
    vectors++; if (ms_tick !== 1'b0) begin miscompares++; $display("FAIL tick_k0: got %0b want 0", ms_tick); end
    step(9);
    vectors++; if (ms_tick !== 1'b1) begin miscompares++; $display("FAIL tick_k9: got %0b want 1", ms_tick); end
    step(11);
    local_init_done = 1'b1;
    n = 0;
    while (init_ok !== 1'b1 && n < 10) begin step(); n++; end
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL init_latency: got %0d want 3", n); end
    vectors++; if (state !== S_RUN || retry_cnt !== 4'd0) begin miscompares++; $display("FAIL run_entry: got state=%0d retry=%0d want 3/0", state, retry_cnt); end
  endtask

  task automatic test_retry_fail();
    int n;
    enable = 1'b0; local_init_done = 1'b0;
    step();
    vectors++; if (state !== S_IDLE) begin miscompares++; $display("FAIL run_disable: got %0d want 0", state); end
    step(3);
    enable = 1'b1;
    step();
    for (int a = 0; a < 3; a++) begin
      count_state(S_RESET, n);
      vectors++; if (n !== 5) begin miscompares++; $display("FAIL retry_pulse%0d: got %0d want 5", a, n); end
      count_state(S_WAIT, n);
      vectors++; if (n !== 40) begin miscompares++; $display("FAIL retry_wait%0d: got %0d want 40", a, n); end
      if (a < 2) begin
        vectors++; if (state !== S_HOLD || retry_cnt !== 4'(a + 1)) begin miscompares++; $display("FAIL retry_hold%0d: got state=%0d retry=%0d want 4/%0d", a, state, retry_cnt, a + 1); end
        count_state(S_HOLD, n);
        vectors++; if (n !== 20) begin miscompares++; $display("FAIL holdoff_len%0d: got %0d want 20", a, n); end
      end
    end
    vectors++; if (state !== S_FAIL || init_fail !== 1'b1) begin miscompares++; $display("FAIL fail_entry: got state=%0d fail=%0b want 5/1", state, init_fail); end
    vectors++; if (retry_cnt !== 4'd2 || ddr_rst_out !== 1'b0) begin miscompares++; $display("FAIL fail_outs: got retry=%0d ddr=%0b want 2/0", retry_cnt, ddr_rst_out); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++; if (state !== S_IDLE || retry_cnt !== 4'd0 || init_fail !== 1'b0) begin miscompares++; $display("FAIL clear_idle: got state=%0d retry=%0d fail=%0b want 0/0/0", state, retry_cnt, init_fail); end
    step();
    vectors++; if (state !== S_RESET || ddr_rst_out !== 1'b1) begin miscompares++; $display("FAIL clear_restart: got state=%0d ddr=%0b want 1/1", state, ddr_rst_out); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_loss();
    int n;
    local_init_done = 1'b1;
    step(3);
    enable = 1'b1;
    wait_state(S_RUN, 30, "loss_reach_run");
    vectors++; if (loss_cnt !== 8'd0) begin miscompares++; $display("FAIL loss_init: got %0d want 0", loss_cnt); end
    local_init_done = 1'b0; step(2); local_init_done = 1'b1;
    step(6);
    vectors++; if (state !== S_RUN || loss_cnt !== 8'd0) begin miscompares++; $display("FAIL short_drop: got state=%0d loss=%0d want 3/0", state, loss_cnt); end
    local_init_done = 1'b0; step(3); local_init_done = 1'b1;
    wait_state(S_HOLD, 10, "loss_holdoff");
    vectors++; if (loss_cnt !== 8'd1 || init_ok !== 1'b0) begin miscompares++; $display("FAIL loss_count: got loss=%0d ok=%0b want 1/0", loss_cnt, init_ok); end
    count_state(S_HOLD, n);
    vectors++; if (n !== 20 || state !== S_RESET) begin miscompares++; $display("FAIL loss_repulse: got len=%0d state=%0d want 20/1", n, state); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_abort();
    local_init_done = 1'b0;
    step(3);
    enable = 1'b1;
    wait_state(S_HOLD, 100, "abort_holdoff");
    vectors++; if (retry_cnt !== 4'd1) begin miscompares++; $display("FAIL abort_retry_pre: got %0d want 1", retry_cnt); end
    wait_state(S_RESET, 30, "abort_reset");
    step(2);
    vectors++; if (ddr_rst_out !== 1'b1) begin miscompares++; $display("FAIL abort_mid: got %0b want 1", ddr_rst_out); end
    enable = 1'b0;
    step();
    vectors++; if (ddr_rst_out !== 1'b0 || state !== S_IDLE || retry_cnt !== 4'd0) begin miscompares++; $display("FAIL abort_idle: got ddr=%0b state=%0d retry=%0d want 0/0/0", ddr_rst_out, state, retry_cnt); end
  endtask

  task automatic test_timeout_race();
    enable = 1'b1;
    wait_state(S_WAIT, 20, "race_wait");
    step(37);
    local_init_done = 1'b1;
    step(2);
    vectors++; if (state !== S_WAIT) begin miscompares++; $display("FAIL race_pre: got %0d want 2", state); end
    step();
    vectors++; if (state !== S_RUN || retry_cnt !== 4'd0 || init_ok !== 1'b1) begin miscompares++; $display("FAIL race_run: got state=%0d retry=%0d ok=%0b want 3/0/1", state, retry_cnt, init_ok); end
    enable = 1'b0; local_init_done = 1'b0;
    step(4);
    enable = 1'b1;
    wait_state(S_FAIL, 400, "race_fail");
    enable = 1'b0;
    step();
    vectors++; if (state !== S_FAIL) begin miscompares++; $display("FAIL fail_ignores_en: got %0d want 5", state); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++; if (state !== S_IDLE || init_fail !== 1'b0 || retry_cnt !== 4'd0) begin miscompares++; $display("FAIL clear_with_dis: got state=%0d fail=%0b retry=%0d want 0/0/0", state, init_fail, retry_cnt); end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    wait_state(S_HOLD, 100, "ar_holdoff");
    wait_state(S_WAIT, 40, "ar_wait2");
    step(5);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (state !== S_IDLE || retry_cnt !== 4'd0 || loss_cnt !== 8'd0) begin miscompares++; $display("FAIL async_cnts: got state=%0d retry=%0d loss=%0d want 0/0/0", state, retry_cnt, loss_cnt); end
    vectors++; if (ddr_rst_out !== 1'b0 || init_ok !== 1'b0 || init_fail !== 1'b0 || ms_tick !== 1'b0) begin miscompares++; $display("FAIL async_outs: got ddr=%0b ok=%0b fail=%0b tick=%0b want 0", ddr_rst_out, init_ok, init_fail, ms_tick); end
    #2 rst_n = 1'b1;
    step();
    vectors++; if (state !== S_RESET) begin miscompares++; $display("FAIL async_restart: got %0d want 1", state); end
    local_init_done = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wait_state(S_RUN, 100, "sat_run");
      local_init_done = 1'b0;
      wait_state(S_HOLD, 20, "sat_hold");
      local_init_done = 1'b1;
      if (i == 254) begin
        vectors++; if (loss_cnt !== 8'd255) begin miscompares++; $display("FAIL loss_255: got %0d want 255", loss_cnt); end
      end
    end
    vectors++; if (loss_cnt !== 8'd255) begin miscompares++; $display("FAIL loss_sat: got %0d want 255", loss_cnt); end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_retry_fail();
    test_loss();
    test_abort();
    test_timeout_race();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
